fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the PC register. It issues the current PC to instruction memory over a request/grant port and accepts in-order, variable-latency responses. Fetched instructions are buffered with their PCs and presented to decode through a valid/ready handshake. It drives the PC register's active-low-advance enable so the PC moves only when a fetch is granted or a redirect loads. On redirect it flushes the buffer and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction-fetch stage.
package fetch_pkg;
  localparam int FETCH_SIZE  = 32;
  localparam int FETCH_IW    = 32;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is never reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues pc to imem, tags in-order responses with their pc and
// buffers them for decode; redirect flushes the buffer and kills in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int SIZE  = FETCH_SIZE,
  parameter int IW    = FETCH_IW,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] pc,
  output logic            pc_hold,
  input  logic            redirect,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [IW-1:0]   imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [IW-1:0]   id_instr,
  output logic [SIZE-1:0] id_pc
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  logic [CW-1:0]      outst, kill, ibuf_cnt, tag_cnt;
  logic               ibuf_full, ibuf_empty, tag_full, tag_empty;
  logic [SIZE-1:0]    tag_pc;
  logic [SIZE+IW-1:0] ibuf_dout;
  logic               grant, resp_keep, id_pop;
  logic [CW:0]        occupancy;

  assign id_valid = !ibuf_empty;
  assign id_pop   = id_valid && id_ready && !redirect;

  // A slot freed by this cycle's decode pop is reusable at once, which is what
  // lets DEPTH=2 with single-cycle memory sustain one fetch per cycle.
  assign occupancy = {1'b0, ibuf_cnt} + {1'b0, outst} - (CW+1)'(id_pop);
  assign imem_req  = !redirect && (occupancy < DEPTH_S);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign pc_hold   = !(grant || redirect);
  assign resp_keep = imem_rvalid && (kill == '0) && !redirect;

  assign id_pc    = id_valid ? ibuf_dout[SIZE+IW-1:IW] : '0;
  assign id_instr = id_valid ? ibuf_dout[IW-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst <= '0;
      kill  <= '0;
    end else begin
      outst <= outst + CW'(grant) - CW'(imem_rvalid);
      if (redirect)
        kill <= outst - CW'(imem_rvalid);
      else if (imem_rvalid && (kill != '0))
        kill <= kill - CW'(1);
    end
  end

  sync_fifo #(.WIDTH(SIZE), .DEPTH(DEPTH)) tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (resp_keep),
    .flush (redirect),
    .din   (pc),
    .dout  (tag_pc),
    .count (tag_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sync_fifo #(.WIDTH(SIZE+IW), .DEPTH(DEPTH)) ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_keep),
    .pop   (id_pop),
    .flush (redirect),
    .din   ({tag_pc, imem_rdata}),
    .dout  (ibuf_dout),
    .count (ibuf_cnt),
    .full  (ibuf_full),
    .empty (ibuf_empty)
  );

  // Every outstanding request is either tagged for delivery or marked for kill.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outst != '0));
  a_tag_balance: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, tag_cnt} + {1'b0, kill}) == {1'b0, outst});
  a_tag_avail: assert property (@(posedge clk) disable iff (!rst)
    resp_keep |-> !tag_empty);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst)
    grant |-> (!tag_full || resp_keep));
  a_no_ibuf_overflow: assert property (@(posedge clk) disable iff (!rst)
    resp_keep |-> (!ibuf_full || id_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and in-order variable-latency memory around the DUT,
// with a queue-level model of what decode must see.
module tb_fetch_unit;
  localparam int SIZE  = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] pc = '0;
  logic            pc_hold;
  logic            redirect = 1'b0;
  logic            imem_req;
  logic [SIZE-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [IW-1:0]   imem_rdata = '0;
  logic            id_valid;
  logic            id_ready = 1'b0;
  logic [IW-1:0]   id_instr;
  logic [SIZE-1:0] id_pc;

  fetch_unit #(.SIZE(SIZE), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_hold     (pc_hold),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int cyc; } ent_t;

  req_t pend[$];   // memory side: granted, response not yet returned
  ent_t ibq[$];    // what decode should be offered, oldest first
  ent_t dels[$];   // what decode actually accepted from the DUT
  int checks = 0, failures = 0;
  int cyc, epoch, last_due, first_grant, first_valid;
  int lat_lo = 1, lat_hi = 1;
  bit rand_mode = 0, hold_s = 1, redir_s = 0;
  logic [31:0] redir_tgt = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; id_ready = 1'b0; rand_mode = 0;
    pend.delete(); ibq.delete(); dels.delete();
    epoch = 0; last_due = -1; first_grant = -1; first_valid = -1;
    hold_s = 1; redir_s = 0; pc = start_pc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc = 0;
  endtask

  // Negedge: compare DUT against the model, then advance model and memory.
  task automatic tick_a();
    int n_ib, lat, due;
    bit ev, pop, ereq, ehold;
    req_t r;
    @(negedge clk);
    n_ib  = ibq.size();
    ev    = (n_ib > 0);
    pop   = ev && id_ready && !redirect;
    ereq  = !redirect && ((n_ib - int'(pop) + pend.size()) < DEPTH);
    ehold = !((ereq && imem_gnt) || redirect);
    chk("imem_req", 32'(imem_req), 32'(ereq));
    chk("imem_addr", imem_addr, pc);
    chk("pc_hold", 32'(pc_hold), 32'(ehold));
    chk("id_valid", 32'(id_valid), 32'(ev));
    chk("id_pc", id_pc, ev ? ibq[0].pc : 32'h0);
    chk("id_instr", id_instr, ev ? ibq[0].instr : 32'h0);

    if (id_valid && id_ready && !redirect) dels.push_back('{id_pc, id_instr, cyc});
    if (id_valid && first_valid < 0) first_valid = cyc;
    if (pop) void'(ibq.pop_front());
    if (imem_rvalid && pend.size() > 0) begin
      r = pend.pop_front();
      if (!redirect && r.epoch == epoch) ibq.push_back('{r.addr, instr_of(r.addr), 0});
    end
    if (redirect) begin
      ibq.delete();
      epoch++;
    end
    if (imem_req && imem_gnt) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{imem_addr, epoch, due});
      if (first_grant < 0) first_grant = cyc;
    end
    chk("outst_max", 32'(pend.size() <= DEPTH), 32'd1);
    hold_s  = pc_hold;
    redir_s = redirect;
  endtask

  // Just after posedge: PC register update, memory response, next-cycle inputs.
  task automatic tick_b();
    @(posedge clk);
    #1;
    if (!hold_s) pc = redir_s ? redir_tgt : pc + 32'd4;
    redirect = 1'b0;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    if (rand_mode) begin
      id_ready = 1'($urandom_range(1, 0));
      imem_gnt = ($urandom_range(3, 0) != 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick_a();
      tick_b();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs while held in reset from time zero.
    #12;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_pc_hold", 32'(pc_hold), 32'd1);

    // Streaming: latency 1, always ready.
    do_reset(32'h0);
    lat_lo = 1; lat_hi = 1;
    imem_gnt = 1'b1; id_ready = 1'b1;
    run(10);
    chk("t1_first_valid_lat", 32'(first_valid - first_grant), 32'd2);
    chk("t1_del_count", 32'(dels.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", dels[i].pc, 32'(4 * i));
      chk("t1_instr", dels[i].instr, instr_of(32'(4 * i)));
      chk("t1_one_per_cycle", 32'(dels[i].cyc - dels[0].cyc), 32'(i));
    end
    // Asynchronous reset in the middle of streaming.
    chk("t1_busy_before_rst", 32'(id_valid), 32'd1);
    imem_gnt = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_id_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_id_pc", id_pc, 32'h0);
    chk("mid_rst_id_instr", id_instr, 32'h0);
    chk("mid_rst_imem_req", 32'(imem_req), 32'd1);
    chk("mid_rst_pc_hold", 32'(pc_hold), 32'd1);

    // Decode stalled: two grants fill the buffer, then fetch resumes.
    do_reset(32'h0);
    imem_gnt = 1'b1; id_ready = 1'b0;
    run(5);
    tick_a();
    chk("t2_req_dropped", 32'(imem_req), 32'd0);
    chk("t2_pc_hold", 32'(pc_hold), 32'd1);
    chk("t2_pc_frozen", pc, 32'h8);
    chk("t2_head_pc", id_pc, 32'h0);
    tick_b();
    id_ready = 1'b1;
    run(10);
    for (int i = 0; i < 5; i++) chk("t2_resume_pc", dels[i].pc, 32'(4 * i));

    // Memory withholds grant for three cycles.
    do_reset(32'h40);
    imem_gnt = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_a();
      chk("t3_hold_nogrant", 32'(pc_hold), 32'd1);
      chk("t3_pc_const", pc, 32'h40);
      tick_b();
    end
    imem_gnt = 1'b1;
    tick_a();
    chk("t3_hold_on_grant", 32'(pc_hold), 32'd0);
    tick_b();
    imem_gnt = 1'b0;
    tick_a();
    chk("t3_hold_after", 32'(pc_hold), 32'd1);
    chk("t3_pc_step", pc, 32'h44);
    tick_b();
    imem_gnt = 1'b1;
    run(6);
    chk("t3_del0", dels[0].pc, 32'h40);
    chk("t3_del1", dels[1].pc, 32'h44);

    // Redirect with two requests in flight; both responses must be dropped.
    do_reset(32'h10);
    lat_lo = 3; lat_hi = 3;
    imem_gnt = 1'b1; id_ready = 1'b1;
    run(2);
    redirect = 1'b1; redir_tgt = 32'h100;
    tick_a();
    chk("t4_hold_redirect", 32'(pc_hold), 32'd0);
    chk("t4_req_redirect", 32'(imem_req), 32'd0);
    tick_b();
    run(12);
    chk("t4_first_pc", dels[0].pc, 32'h100);
    chk("t4_first_instr", dels[0].instr, instr_of(32'h100));
    chk("t4_second_pc", dels[1].pc, 32'h104);

    // Redirect coinciding with a response and a decode handshake.
    do_reset(32'h200);
    lat_lo = 1; lat_hi = 1;
    imem_gnt = 1'b1; id_ready = 1'b1;
    run(2);
    redirect = 1'b1; redir_tgt = 32'h300;
    tick_a();
    chk("t5_valid_at_redirect", 32'(id_valid), 32'd1);
    chk("t5_hold_redirect", 32'(pc_hold), 32'd0);
    chk("t5_req_redirect", 32'(imem_req), 32'd0);
    tick_b();
    tick_a();
    chk("t5_flushed", 32'(id_valid), 32'd0);
    tick_b();
    run(8);
    chk("t5_first_pc", dels[0].pc, 32'h300);

    // Random latency 1..4, random grant and decode stalls, 200 fetches.
    do_reset(32'h1000);
    lat_lo = 1; lat_hi = 4;
    rand_mode = 1;
    imem_gnt = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 6000 && dels.size() < 200; k++) begin
      tick_a();
      tick_b();
    end
    chk("rand_count_reached", 32'(dels.size() >= 200), 32'd1);
    for (int i = 0; i < 200 && i < dels.size(); i++) begin
      chk("rand_pc_order", dels[i].pc, 32'h1000 + 32'(4 * i));
      chk("rand_instr", dels[i].instr, instr_of(32'h1000 + 32'(4 * i)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
